// File: rtl/f32m_acc_ctrl_pkg.sv
// Shared definitions for the GF(3^{2M}) accumulator controller: field sizes,
// GF(3) digit encodings, controller state encoding and the single-digit adder.
package f32m_acc_ctrl_pkg;

    localparam int M     = 97;
    localparam int WIDTH = 2 * M - 1;
    localparam int W2    = 4 * M - 1;

    localparam logic [W2:0] ZERO = '0;

    localparam logic [1:0] GF3_ZERO = 2'b00;
    localparam logic [1:0] GF3_ONE  = 2'b01;
    localparam logic [1:0] GF3_TWO  = 2'b10;
    localparam logic [1:0] GF3_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Any pairing that involves the illegal 11 code falls to the default and yields 00.
    function automatic logic [1:0] gf3_add(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        r = GF3_ZERO;
        case ({a, b})
            {GF3_ZERO, GF3_ZERO}: r = GF3_ZERO;
            {GF3_ZERO, GF3_ONE }: r = GF3_ONE;
            {GF3_ZERO, GF3_TWO }: r = GF3_TWO;
            {GF3_ONE,  GF3_ZERO}: r = GF3_ONE;
            {GF3_ONE,  GF3_ONE }: r = GF3_TWO;
            {GF3_ONE,  GF3_TWO }: r = GF3_ZERO;
            {GF3_TWO,  GF3_ZERO}: r = GF3_TWO;
            {GF3_TWO,  GF3_ONE }: r = GF3_ZERO;
            {GF3_TWO,  GF3_TWO }: r = GF3_ONE;
            default:              r = GF3_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/f32m_acc_ctrl_if.sv
// Operand stream, start/count request and result/status bundle of the accumulator.
interface f32m_acc_ctrl_if #(
    parameter int M  = f32m_acc_ctrl_pkg::M,
    parameter int CW = 4
);
    logic              start;
    logic [CW-1:0]     count;
    logic              in_valid;
    logic [4*M-1:0]    in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [4*M-1:0]    c;

    modport master (
        output start, count, in_valid, in_data,
        input  in_ready, busy, done, c
    );

    modport slave (
        input  start, count, in_valid, in_data,
        output in_ready, busy, done, c
    );
endinterface

// File: rtl/f32m_add.sv
// Carry-free GF(3^{2M}) adder: 2M independent GF(3) digit adders, so the two
// GF(3^M) halves never interact.
module f32m_add
    import f32m_acc_ctrl_pkg::gf3_add;
#(
    parameter int M = 97
) (
    input  logic [4*M-1:0] a,
    input  logic [4*M-1:0] b,
    output logic [4*M-1:0] sum
);

    for (genvar gi = 0; gi < 2 * M; gi++) begin : g_digit
        assign sum[2*gi +: 2] = gf3_add(a[2*gi +: 2], b[2*gi +: 2]);
    end

endmodule

// File: rtl/f32m_acc_ctrl.sv
// Sequential GF(3^{2M}) accumulator: sums a programmed number of streamed
// operands through one shared f32m_add, with a start/done handshake.
module f32m_acc_ctrl
    import f32m_acc_ctrl_pkg::state_t, f32m_acc_ctrl_pkg::IDLE,
           f32m_acc_ctrl_pkg::ACCUM, f32m_acc_ctrl_pkg::DONE;
#(
    parameter int M  = 97,
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              reset,
    f32m_acc_ctrl_if.slave    bus
);

    localparam int DW = 4 * M;

    state_t          state_reg, state_next;
    logic [DW-1:0]   acc_reg, acc_next;
    logic [CW-1:0]   remaining_reg, remaining_next;
    logic            fresh_reg, fresh_next;
    logic            handshake;
    logic [DW-1:0]   add_lhs;
    logic [DW-1:0]   add_sum;

    assign handshake = bus.in_valid && (state_reg == ACCUM);

    // The clear of the accumulator is folded into the first handshake so the
    // previous result stays visible on c until new data is actually absorbed.
    assign add_lhs = fresh_reg ? '0 : acc_reg;

    f32m_add #(.M(M)) u_add (
        .a   (add_lhs),
        .b   (bus.in_data),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            remaining_reg <= '0;
            fresh_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            remaining_reg <= remaining_next;
            fresh_reg     <= fresh_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        remaining_next = remaining_reg;
        fresh_next     = fresh_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    remaining_next = bus.count;
                    if (bus.count == '0) begin
                        acc_next   = '0;
                        fresh_next = 1'b0;
                        state_next = DONE;
                    end else begin
                        fresh_next = 1'b1;
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (handshake) begin
                    acc_next       = add_sum;
                    fresh_next     = 1'b0;
                    remaining_next = remaining_reg - CW'(1);
                    if (remaining_reg == CW'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready = (state_reg == ACCUM);
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.c        = acc_reg;

endmodule

// File: tb/tb_f32m_acc_ctrl.sv
// Self-checking bench for f32m_acc_ctrl: expected sums are queued when a run
// is driven and popped by a monitor whenever done pulses.
module tb_f32m_acc_ctrl;
    import f32m_acc_ctrl_pkg::*;

    localparam int CW = 4;
    localparam int DW = 4 * M;

    logic clk = 1'b0;
    logic reset = 1'b1;

    f32m_acc_ctrl_if #(.M(M), .CW(CW)) bus ();

    f32m_acc_ctrl #(.M(M), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] expq[$];
    logic [DW-1:0] sb_exp;

    // Reference digit-wise GF(3) sum; an illegal 11 digit in either operand gives 0.
    function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int d = 0; d < 2 * M; d++) begin
            int x;
            int y;
            x = int'(a[2*d +: 2]);
            y = int'(b[2*d +: 2]);
            if (x == 3 || y == 3) r[2*d +: 2] = 2'd0;
            else                  r[2*d +: 2] = 2'((x + y) % 3);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_done: c=%h, no result expected", bus.c);
            end else begin
                sb_exp = expq.pop_front();
                if (bus.c !== sb_exp) begin
                    miscompares++;
                    $display("FAIL sb_result: c=%h expected %h", bus.c, sb_exp);
                end else begin
                    $display("done: c=%h", bus.c);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.start    = 1'b0;
        bus.count    = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Drives one run with in_valid held high; returns the cycle of done (start = cycle 0), -1 on timeout.
    task automatic stream_run(input int cnt, input logic [DW-1:0] ops[$], output int done_cyc);
        logic [DW-1:0] e;
        int k;
        logic hs;
        e = '0;
        k = 0;
        for (int i = 0; i < cnt; i++) e = model_add(e, ops[i]);
        expq.push_back(e);
        bus.start    = 1'b1;
        bus.count    = CW'(cnt);
        bus.in_valid = (cnt > 0);
        if (cnt > 0) bus.in_data = ops[0];
        tick;
        bus.start = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= cnt + 8; cyc++) begin
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            hs = (bus.in_ready === 1'b1) && bus.in_valid;
            tick;
            if (hs) k++;
            bus.in_valid = (k < cnt);
            if (k < cnt) bus.in_data = ops[k];
            else         bus.in_data = '0;
        end
        bus.in_valid = 1'b0;
        $display("run: count=%0d done_cycle=%0d", cnt, done_cyc);
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.count = 4'd3;
        bus.in_valid = 1'b1;
        repeat (3) tick;
        vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0)     begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        vectors++; if (bus.c !== '0)          begin miscompares++; $display("FAIL reset_c: got %h want 0", bus.c); end
        clear_inputs();
        reset = 1'b0;
        tick;
        vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
        $display("test_reset complete");
    endtask

    task automatic test_single_digit;
        logic [DW-1:0] one;
        logic [DW-1:0] e;
        one = DW'(1);
        e = '0;
        repeat (3) e = model_add(e, one);
        expq.push_back(e);
        bus.start = 1'b1;
        bus.count = 4'd3;
        bus.in_valid = 1'b1;
        bus.in_data = one;
        tick;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            vectors++;
            if (bus.in_ready !== (cyc <= 3)) begin
                miscompares++; $display("FAIL single_in_ready cycle %0d: got %b want %b", cyc, bus.in_ready, (cyc <= 3));
            end
            vectors++;
            if (bus.done !== (cyc == 4)) begin
                miscompares++; $display("FAIL single_done cycle %0d: got %b want %b", cyc, bus.done, (cyc == 4));
            end
            if (cyc == 4) begin
                vectors++;
                if (bus.c !== '0) begin miscompares++; $display("FAIL single_c: got %h want 0", bus.c); end
            end
            tick;
        end
        clear_inputs();
        $display("test_single_digit complete");
    endtask

    task automatic test_mixed;
        logic [DW-1:0] ops[$];
        int dc;
        ops = {};
        ops.push_back(DW'(9));
        ops.push_back(DW'(6));
        stream_run(2, ops, dc);
        vectors++; if (dc != 3)       begin miscompares++; $display("FAIL mixed_a_latency: done cycle %0d want 3", dc); end
        vectors++; if (bus.c !== '0)  begin miscompares++; $display("FAIL mixed_a_c: got %h want 0", bus.c); end
        tick;
        ops = {};
        ops.push_back(DW'(5));
        ops.push_back(DW'(5));
        stream_run(2, ops, dc);
        vectors++; if (dc != 3)            begin miscompares++; $display("FAIL mixed_b_latency: done cycle %0d want 3", dc); end
        vectors++; if (bus.c !== DW'(10))  begin miscompares++; $display("FAIL mixed_b_c: got %h want a", bus.c); end
        tick;
        vectors++; if (bus.c !== DW'(10))  begin miscompares++; $display("FAIL mixed_b_hold: got %h want a", bus.c); end
        $display("test_mixed complete");
    endtask

    task automatic test_stall;
        logic [DW-1:0] one;
        one = DW'(1);
        expq.push_back(model_add(model_add('0, one), one));
        bus.start = 1'b1;
        bus.count = 4'd2;
        bus.in_valid = 1'b1;
        bus.in_data = one;
        tick;
        bus.start = 1'b0;
        tick;
        bus.in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            vectors++; if (bus.c !== one)     begin miscompares++; $display("FAIL stall_hold_c %0d: got %h want 1", s, bus.c); end
            vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL stall_done %0d: got %b want 0", s, bus.done); end
            tick;
        end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_in_ready: got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        vectors++; if (bus.done !== 1'b1)     begin miscompares++; $display("FAIL stall_done_pulse: got %b want 1", bus.done); end
        vectors++; if (bus.c !== DW'(2))      begin miscompares++; $display("FAIL stall_c: got %h want 2", bus.c); end
        tick;
        vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL stall_idle_busy: got %b want 0", bus.busy); end
        clear_inputs();
        $display("test_stall complete");
    endtask

    task automatic test_count_zero;
        expq.push_back('0);
        bus.start = 1'b1;
        bus.count = '0;
        bus.in_valid = 1'b1;
        bus.in_data = DW'(5);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_in_ready_c0: got %b want 0", bus.in_ready); end
        tick;
        bus.start = 1'b0;
        vectors++; if (bus.done !== 1'b1)     begin miscompares++; $display("FAIL zero_done: got %b want 1", bus.done); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_in_ready_c1: got %b want 0", bus.in_ready); end
        vectors++; if (bus.c !== '0)          begin miscompares++; $display("FAIL zero_c: got %h want 0", bus.c); end
        tick;
        vectors++; if (bus.done !== 1'b0)     begin miscompares++; $display("FAIL zero_done_width: got %b want 0", bus.done); end
        vectors++; if (bus.c !== '0)          begin miscompares++; $display("FAIL zero_c_hold: got %h want 0", bus.c); end
        clear_inputs();
        $display("test_count_zero complete");
    endtask

    task automatic test_reset_midrun;
        logic [DW-1:0] ops[$];
        int dc;
        bus.start = 1'b1;
        bus.count = 4'd4;
        bus.in_valid = 1'b1;
        bus.in_data = DW'(1);
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        vectors++; if (bus.c !== DW'(2))      begin miscompares++; $display("FAIL midrun_partial: got %h want 2", bus.c); end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL midrun_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.c !== '0)          begin miscompares++; $display("FAIL midrun_c: got %h want 0", bus.c); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrun_in_ready: got %b want 0", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midrun_done %0d: got %b want 0", i, bus.done); end
            tick;
        end
        ops = {};
        ops.push_back(DW'(2));
        stream_run(1, ops, dc);
        vectors++; if (dc != 2)               begin miscompares++; $display("FAIL midrun_rerun_latency: done cycle %0d want 2", dc); end
        vectors++; if (bus.c !== DW'(2))      begin miscompares++; $display("FAIL midrun_rerun_c: got %h want 2", bus.c); end
        tick;
        $display("test_reset_midrun complete");
    endtask

    task automatic test_ignored_start;
        logic [DW-1:0] e;
        e = '0;
        repeat (3) e = model_add(e, DW'(1));
        expq.push_back(e);
        bus.start = 1'b1;
        bus.count = 4'd3;
        bus.in_valid = 1'b1;
        bus.in_data = DW'(1);
        tick;
        bus.count = 4'd7;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            vectors++;
            if (bus.done !== (cyc == 4)) begin
                miscompares++; $display("FAIL ignstart_done cycle %0d: got %b want %b", cyc, bus.done, (cyc == 4));
            end
            vectors++;
            if (bus.busy !== (cyc <= 4)) begin
                miscompares++; $display("FAIL ignstart_busy cycle %0d: got %b want %b", cyc, bus.busy, (cyc <= 4));
            end
            tick;
            if (cyc == 4) begin
                bus.start = 1'b0;
                bus.in_valid = 1'b0;
            end
        end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignstart_idle: got %b want 0", bus.busy); end
        clear_inputs();
        $display("test_ignored_start complete");
    endtask

    task automatic test_upper_half;
        logic [DW-1:0] ops[$];
        logic [DW-1:0] op;
        logic [DW-1:0] want;
        int dc;
        op = DW'(1) << (2 * M);
        want = DW'(1) << (2 * M + 1);
        ops = {};
        ops.push_back(op);
        ops.push_back(op);
        stream_run(2, ops, dc);
        vectors++; if (dc != 3)                     begin miscompares++; $display("FAIL upper_latency: done cycle %0d want 3", dc); end
        vectors++; if (bus.c[2*M+1] !== 1'b1)       begin miscompares++; $display("FAIL upper_bit: got %b want 1", bus.c[2*M+1]); end
        vectors++; if (bus.c[2*M-1:0] !== '0)       begin miscompares++; $display("FAIL upper_lower_half: got %h want 0", bus.c[2*M-1:0]); end
        vectors++; if (bus.c !== want)              begin miscompares++; $display("FAIL upper_c: got %h want %h", bus.c, want); end
        tick;
        $display("test_upper_half complete");
    endtask

    task automatic test_random_long;
        logic [DW-1:0] ops[$];
        logic [DW-1:0] op;
        int dc;
        ops = {};
        for (int i = 0; i < 15; i++) begin
            op = '0;
            for (int j = 0; j < DW / 32 + 1; j++) op = (op << 32) | DW'($urandom);
            ops.push_back(op);
        end
        stream_run(15, ops, dc);
        vectors++; if (dc != 16) begin miscompares++; $display("FAIL random_latency: done cycle %0d want 16", dc); end
        tick;
        $display("test_random_long complete");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_digit();
        test_mixed();
        test_stall();
        test_count_zero();
        test_reset_midrun();
        test_ignored_start();
        test_upper_half();
        test_random_long();
        repeat (2) tick;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d results never produced, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
